cdc_synchron: RTL and testbench

Single-bit clock-domain-crossing synchronizer with edge detection. It brings an asynchronous input (for example SPI SClk, MOSI or /SS from an external master) into the `sysClk_i` domain through a multi-flop chain. It then emits the synchronized level plus one-cycle rising and falling edge pulses. One instance is used per asynchronous signal, such as in the SPI slave front end.

---
 rtl/cdc_pkg.sv | 16 +
 rtl/cdc_edge_detect.sv | 27 ++
 rtl/cdc_synchron.sv | 86 ++++++++
 tb/tb_cdc_synchron.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants and types for the single-bit synchronizer family.
package cdc_pkg;

    localparam int CDC_DEFAULT_STAGES     = 2;
    localparam int CDC_MIN_STAGES         = 2;
    localparam int CDC_MAX_STAGES         = 8;
    localparam int CDC_DEFAULT_FILTER_LEN = 3;
    localparam int CDC_MIN_FILTER_LEN     = 2;
    localparam int CDC_MAX_FILTER_LEN     = 15;

    typedef struct packed {
        logic rising;
        logic falling;
    } cdc_edge_t;

endpackage

// File: rtl/cdc_edge_detect.sv
// Edge detector for an already-synchronous level: one-cycle rise/fall pulses
// derived from the level and its one-cycle-old copy.
module cdc_edge_detect
    import cdc_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic      sysClk_i,
    input  logic      reset_i_n,
    input  logic      level_i,
    output cdc_edge_t edge_o
);

    logic prev_q;

    always_ff @(posedge sysClk_i) begin
        if (!reset_i_n) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= level_i;
        end
    end

    assign edge_o.rising  = level_i & ~prev_q;
    assign edge_o.falling = ~level_i & prev_q;

endmodule

// File: rtl/cdc_synchron.sv
// Multi-flop synchronizer with edge pulses; defining CDC_SYNCHRON_GLITCH_FILTER_EN
// inserts a stability filter between the last chain flop and sync_o.
module cdc_synchron
    import cdc_pkg::*;
#(
    parameter int   STAGES      = CDC_DEFAULT_STAGES,
    parameter logic RESET_VALUE = 1'b0,
    parameter int   FILTER_LEN  = CDC_DEFAULT_FILTER_LEN
) (
    input  logic sysClk_i,
    input  logic reset_i_n,
    input  logic async_i,
    output logic sync_o,
    output logic rising_o,
    output logic falling_o
);

    if (STAGES < CDC_MIN_STAGES || STAGES > CDC_MAX_STAGES) begin : g_bad_stages
        $fatal(1, "cdc_synchron: STAGES=%0d outside 2..8", STAGES);
    end

    // FILTER_LEN is validated in every build so a configuration stays portable.
    if (FILTER_LEN < CDC_MIN_FILTER_LEN || FILTER_LEN > CDC_MAX_FILTER_LEN) begin : g_bad_filter
        $fatal(1, "cdc_synchron: FILTER_LEN=%0d outside 2..15", FILTER_LEN);
    end

    // Only stage_q[0] ever samples async_i.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage_q;

    always_ff @(posedge sysClk_i) begin
        if (!reset_i_n) begin
            stage_q <= {STAGES{RESET_VALUE}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], async_i};
        end
    end

`ifdef CDC_SYNCHRON_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;

    // The level must disagree with sync_q on FILTER_LEN consecutive edges to pass.
    always_comb begin
        cnt_d  = '0;
        sync_d = sync_q;
        if (stage_q[STAGES-1] != sync_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                sync_d = stage_q[STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysClk_i) begin
        if (!reset_i_n) begin
            sync_q <= RESET_VALUE;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_o = sync_q;
`else
    assign sync_o = stage_q[STAGES-1];
`endif

    cdc_edge_t edge_w;

    cdc_edge_detect #(
        .RESET_VALUE (RESET_VALUE)
    ) u_edge (
        .sysClk_i  (sysClk_i),
        .reset_i_n (reset_i_n),
        .level_i   (sync_o),
        .edge_o    (edge_w)
    );

    assign rising_o  = edge_w.rising;
    assign falling_o = edge_w.falling;

endmodule

// File: tb/tb_cdc_synchron.sv
// Scoreboard bench: two synchronizer configurations share one stimulus stream;
// expectations come from a sample-history model, a monitor compares every cycle.
module tb_cdc_synchron;
    import cdc_pkg::*;

    localparam int   S0   = 2;
    localparam logic RV0  = 1'b0;
    localparam int   S1   = 3;
    localparam logic RV1  = 1'b1;
    localparam int   FL   = 3;
    localparam int   MAXE = 4096;

    logic sysClk_i  = 1'b0;
    logic reset_i_n = 1'b0;
    logic async_i   = 1'b0;
    logic sync0, rise0, fall0;
    logic sync1, rise1, fall1;

    always #5 sysClk_i = ~sysClk_i;

    cdc_synchron #(.STAGES(S0), .RESET_VALUE(RV0), .FILTER_LEN(FL)) u_dut0 (
        .sysClk_i  (sysClk_i),
        .reset_i_n (reset_i_n),
        .async_i   (async_i),
        .sync_o    (sync0),
        .rising_o  (rise0),
        .falling_o (fall0)
    );

    cdc_synchron #(.STAGES(S1), .RESET_VALUE(RV1), .FILTER_LEN(FL)) u_dut1 (
        .sysClk_i  (sysClk_i),
        .reset_i_n (reset_i_n),
        .async_i   (async_i),
        .sync_o    (sync1),
        .rising_o  (rise1),
        .falling_o (fall1)
    );

    // History of what each clock edge sampled, and the model's output level per edge.
    bit   async_h [MAXE];
    bit   rst_h   [MAXE];
    bit   out_h   [2][MAXE];
    int   run_c   [2];
    int   n_edges   = 0;
    int   n_checked = 0;
    int   total     = 0;
    int   bad       = 0;
    logic [5:0] exp_q[$];

    // Level seen at the end of an s-flop chain after edge e.
    function automatic bit raw_after(input int e, input int s, input bit rv);
        if (e - s + 1 < 0) return rv;
        for (int j = e - s + 1; j <= e; j++) begin
            if (rst_h[j]) return rv;
        end
        return async_h[e - s + 1];
    endfunction

    task automatic predict(input int e, input int d, input int s, input bit rv,
                           output bit sy, output bit ri, output bit fa);
        bit prev;
`ifdef CDC_SYNCHRON_GLITCH_FILTER_EN
        bit raw_prev;
        if (rst_h[e]) begin
            out_h[d][e] = rv;
            run_c[d]    = 0;
        end else begin
            raw_prev = raw_after(e - 1, s, rv);
            out_h[d][e] = out_h[d][e-1];
            if (raw_prev != out_h[d][e-1]) begin
                run_c[d]++;
                if (run_c[d] == FL) begin
                    out_h[d][e] = raw_prev;
                    run_c[d]    = 0;
                end
            end else begin
                run_c[d] = 0;
            end
        end
`else
        out_h[d][e] = raw_after(e, s, rv);
`endif
        prev = (e == 0 || rst_h[e]) ? rv : out_h[d][e-1];
        sy = out_h[d][e];
        ri = sy & ~prev;
        fa = ~sy & prev;
    endtask

    task automatic drive(input bit a, input bit rst);
        bit s0, r0, f0, s1, r1, f1;
        @(negedge sysClk_i);
        async_i   = a;
        reset_i_n = ~rst;
        async_h[n_edges] = a;
        rst_h[n_edges]   = rst;
        predict(n_edges, 0, S0, RV0, s0, r0, f0);
        predict(n_edges, 1, S1, RV1, s1, r1, f1);
        exp_q.push_back({s0, r0, f0, s1, r1, f1});
        n_edges++;
    endtask

    task automatic hold(input bit a, input int n);
        for (int i = 0; i < n; i++) drive(a, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle once the first expectation exists.
    initial begin
        logic [5:0] exp_v, got_v;
        forever begin
            @(posedge sysClk_i);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {sync0, rise0, fall0, sync1, rise1, fall1};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL outputs edge=%0d got={s,r,f|s,r,f}=%b required=%b",
                             n_checked, got_v, exp_v);
                end
                total++;
                if ((rise0 & fall0) | (rise1 & fall1)) begin
                    bad++;
                    $display("FAIL edge_overlap edge=%0d got r0f0=%b%b r1f1=%b%b required no overlap",
                             n_checked, rise0, fall0, rise1, fall1);
                end
                n_checked++;
            end
        end
    end

    initial begin
        int run_len;
        bit lvl;

        // Reset held with async_i high, then release.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        hold(1'b1, 8);
        $display("phase reset_hold edges=%0d", n_edges);

        hold(1'b0, 6);
        hold(1'b1, 6);
        hold(1'b0, 6);
        $display("phase latency edges=%0d", n_edges);

        for (int i = 0; i < 16; i++) drive(i[0] == 1'b0, 1'b0);
        hold(1'b0, 6);
        $display("phase fast_toggle edges=%0d", n_edges);

        // Reset lands one cycle after a 0->1 change.
        hold(1'b0, 5);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        hold(1'b1, 6);
        hold(1'b0, 6);
        $display("phase reset_mid edges=%0d", n_edges);

        // Glitch then longer pulse, interesting when the filter is built in.
        hold(1'b0, 8);
        hold(1'b1, 2);
        hold(1'b0, 8);
        hold(1'b1, 5);
        hold(1'b0, 10);
        $display("phase glitch edges=%0d", n_edges);

        lvl = 1'b0;
        for (int i = 0; i < 120; i++) begin
            lvl = ~lvl;
            run_len = $urandom_range(1, 6);
            if ($urandom_range(0, 29) == 0) begin
                drive(lvl, 1'b1);
                run_len = run_len - 1;
            end
            for (int k = 0; k < run_len; k++) drive(lvl, 1'b0);
        end
        hold(1'b0, 10);
        $display("phase random edges=%0d", n_edges);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sysClk_i);
        #2;
        total++;
        if (exp_q.size() != 0 || n_checked != n_edges) begin
            bad++;
            $display("FAIL drain got checked=%0d required=%0d", n_checked, n_edges);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
